// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial add/subtract sequencer. A WIDTH-bit operand pair is captured on
//   start. It is then pushed LSB first through one full-adder cell, one bit per
//   clock, with the carry held in a flop between bits. The registered result
//   and flags update together with a one-cycle done pulse.
//
// Ports
//   clk_i    clock, all state on rising edge
//   rst_i    synchronous active-high reset
//   start_i  request, sampled only when not busy (IDLE or DONE)
//   sub_i    0: A+B+cin, 1: A-B (B inverted, carry-in forced to 1)
//   cin_i    carry-in for add mode
//   op_a_i   operand A
//   op_b_i   operand B
//   busy_o   high while bits are being processed
//   done_o   one-cycle pulse coincident with the result update
//   sum_o    result, held until the next completion
//   cout_o   carry out of the MSB (subtract: 1 = no borrow)
//   ovf_o    signed overflow
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             sub_i,
   input  logic             cin_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_sr_q, b_sr_q, s_sr_q;
   logic [WIDTH-1:0] s_sr_d;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, sub_q;
   logic             busy_q, done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q, ovf_q;

   // Single full-adder cell; B is inverted here for subtract.
   logic fa_a, fa_b, fa_s, fa_c;
   logic carry_msb;

   always_comb begin
      fa_a      = a_sr_q[0];
      fa_b      = b_sr_q[0] ^ sub_q;
      fa_s      = fa_a ^ fa_b ^ carry_q;
      fa_c      = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);
      // Sum bits enter at the MSB end so after WIDTH shifts bit 0 sits at LSB.
      s_sr_d    = {fa_s, s_sr_q[WIDTH-1:1]};
      // On the last bit the carry flop holds the carry into the MSB.
      carry_msb = carry_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  a_sr_q  <= op_a_i;
                  b_sr_q  <= op_b_i;
                  s_sr_q  <= '0;
                  cnt_q   <= '0;
                  carry_q <= sub_i ? 1'b1 : cin_i;
                  sub_q   <= sub_i;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RUN: begin
               a_sr_q  <= a_sr_q >> 1;
               b_sr_q  <= b_sr_q >> 1;
               s_sr_q  <= s_sr_d;
               carry_q <= fa_c;
               if (cnt_q == LAST) begin
                  cnt_q   <= '0;
                  sum_q   <= s_sr_d;
                  cout_q  <= fa_c;
                  ovf_q   <= carry_msb ^ fa_c;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign sum_o  = sum_q;
   assign cout_o = cout_q;
   assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Directed and random stimulus for serial_add_ctrl (WIDTH=8), compared
//   against a plain-arithmetic reference of A + B + cin / A - B.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, start, sub, cin;
   logic [W-1:0] op_a, op_b, sum;
   logic         busy, done, cout, ovf;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] last_sum;
   logic         last_cout, last_ovf;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .start_i(start),
      .sub_i  (sub),
      .cin_i  (cin),
      .op_a_i (op_a),
      .op_b_i (op_b),
      .busy_o (busy),
      .done_o (done),
      .sum_o  (sum),
      .cout_o (cout),
      .ovf_o  (ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: integer add with sign-rule overflow.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic c,
                                 output logic [W-1:0] es, output logic ec, output logic eo);
      logic [W-1:0] bb;
      logic [W:0]   r;
      bb = s ? ~b : b;
      r  = {1'b0, a} + {1'b0, bb} + (W+1)'(s ? 1'b1 : c);
      es = r[W-1:0];
      ec = r[W];
      eo = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
   endfunction

   // One operation: start pulse, W busy cycles, done with result, then idle.
   // poke=1 changes operands and pulses start mid-run.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic c, input logic poke);
      logic [W-1:0] es;
      logic         ec, eo;
      int           bc, bad;
      model(a, b, s, c, es, ec, eo);
      @(negedge clk);
      op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bc = 0; bad = 0;
      for (int i = 0; i < W; i++) begin
         if (i > 0) @(negedge clk);
         if (busy) bc++;
         if (done !== 1'b0 || sum !== last_sum || cout !== last_cout || ovf !== last_ovf) bad++;
         if (poke && i == 3) begin
            op_a = ~a; op_b = ~b; sub = ~s; start = 1'b1;
         end
         if (poke && i == 4) start = 1'b0;
      end
      chk("busy_cycles", bc, W);
      chk("held_during_run", bad, 0);
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("busy_at_done", busy, 0);
      chk("sum", sum, es);
      chk("cout", cout, ec);
      chk("ovf", ovf, eo);
      last_sum = es; last_cout = ec; last_ovf = eo;
      @(negedge clk);
      chk("done_falls", done, 0);
      chk("idle_after", busy, 0);
   endtask

   logic [W-1:0] cha [4];
   logic [W-1:0] chb [4];

   initial begin
      logic [W-1:0] es;
      logic         ec, eo;
      int           bc, bad;

      rst = 1'b1; start = 1'b1; sub = 1'b0; cin = 1'b0; op_a = 8'h11; op_b = 8'h22;
      last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
      repeat (2) @(negedge clk);
      // Reset wins over a simultaneous start.
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      rst = 1'b0; start = 1'b0;

      run_op(8'h5A, 8'hA5, 1'b0, 1'b0, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
      run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
      run_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
      run_op(8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
      run_op(8'h20, 8'h10, 1'b1, 1'b0, 1'b0);
      // Mid-run operand change and start pulse must not disturb anything.
      run_op(8'h3C, 8'h4B, 1'b0, 1'b1, 1'b1);

      // Start held high: each DONE cycle accepts the next operand pair.
      cha[0] = 8'h12; chb[0] = 8'h34;
      cha[1] = 8'h80; chb[1] = 8'h7F;
      cha[2] = 8'hF0; chb[2] = 8'h11;
      cha[3] = 8'h40; chb[3] = 8'h40;
      @(negedge clk);
      op_a = cha[0]; op_b = chb[0]; sub = 1'b0; cin = 1'b0; start = 1'b1;
      for (int n = 0; n < 4; n++) begin
         bc = 0; bad = 0;
         for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done !== 1'b0) bad++;
            if (i == 1 && n < 3) begin
               op_a = cha[n+1]; op_b = chb[n+1];
            end
         end
         @(negedge clk);
         model(cha[n], chb[n], 1'b0, 1'b0, es, ec, eo);
         chk("b2b_busy_cycles", bc, W);
         chk("b2b_no_early_done", bad, 0);
         chk("b2b_done", done, 1);
         chk("b2b_sum", sum, es);
         chk("b2b_cout", cout, ec);
         chk("b2b_ovf", ovf, eo);
         last_sum = es; last_cout = ec; last_ovf = eo;
         if (n == 3) start = 1'b0;
      end
      @(negedge clk);
      chk("b2b_done_falls", done, 0);
      chk("b2b_idle", busy, 0);

      // Reset part-way through an operation.
      @(negedge clk);
      op_a = 8'h33; op_b = 8'h44; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_sum", sum, 0);
      chk("abort_cout", cout, 0);
      chk("abort_ovf", ovf, 0);
      bad = 0;
      repeat (W + 3) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      chk("abort_no_late_done", bad, 0);
      last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
      run_op(8'h33, 8'h44, 1'b0, 1'b0, 1'b0);

      // Random operands and modes.
      for (int r = 0; r < 24; r++)
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
